// File: rtl/pc_unit.sv
// Fetch-stage program counter with hold-after-reset, fetch handshake, trap/redirect priority
// and misaligned-redirect fault handling. Optional macro PC_COMPRESSED_EN enables 16-bit fetch steps.
module pc_unit #(
    parameter int unsigned      XLEN              = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR      = '0,
    parameter int unsigned      RESET_HOLD_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            fetch_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_addr,
`ifdef PC_COMPRESSED_EN
    input  logic            is_compressed,
`endif
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_seq,
    output logic            fetch_valid,
    output logic            misalign_fault,
    output logic [XLEN-1:0] misalign_addr
);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RUN,
        ST_FAULT
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD_CYCLES - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_hold_cnt;
    logic [3:0]      w_hold_cnt_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] r_maddr;
    logic [XLEN-1:0] w_maddr_nxt;
    logic [XLEN-1:0] w_inc;
    logic            r_fetch_valid;
    logic            r_fault;
    logic            w_fault_nxt;
    logic            w_misaligned;

`ifdef PC_COMPRESSED_EN
    assign w_inc        = is_compressed ? XLEN'(2) : XLEN'(4);
    assign w_misaligned = redirect_addr[0];
`else
    assign w_inc        = XLEN'(4);
    assign w_misaligned = (redirect_addr[1:0] != 2'b00);
`endif

    assign pc_seq = r_pc + w_inc;

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_hold_cnt_nxt = r_hold_cnt;
        w_fault_nxt    = 1'b0;
        w_maddr_nxt    = r_maddr;
        unique case (r_state)
            ST_HOLD: begin
                w_hold_cnt_nxt = r_hold_cnt + 4'd1;
                if (trap_valid) begin
                    w_pc_nxt    = trap_addr;
                    w_state_nxt = ST_RUN;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // Trap and redirect abandon the in-flight fetch, so they bypass stall/fetch_ready.
                if (trap_valid) begin
                    w_pc_nxt = trap_addr;
                end else if (redirect_valid) begin
                    if (w_misaligned) begin
                        w_fault_nxt = 1'b1;
                        w_maddr_nxt = redirect_addr;
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_pc_nxt = redirect_addr;
                    end
                end else if (!stall && fetch_ready) begin
                    w_pc_nxt = pc_seq;
                end
            end
            ST_FAULT: begin
                if (trap_valid) begin
                    w_pc_nxt    = trap_addr;
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_HOLD;
            r_hold_cnt    <= '0;
            r_pc          <= RESET_VECTOR;
            r_maddr       <= '0;
            r_fault       <= 1'b0;
            r_fetch_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_hold_cnt    <= w_hold_cnt_nxt;
            r_pc          <= w_pc_nxt;
            r_maddr       <= w_maddr_nxt;
            r_fault       <= w_fault_nxt;
            r_fetch_valid <= (w_state_nxt == ST_RUN);
        end
    end

    assign pc             = r_pc;
    assign fetch_valid    = r_fetch_valid;
    assign misalign_fault = r_fault;
    assign misalign_addr  = r_maddr;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios followed by random traffic, all checked against
// a cycle-level reference model of the program-counter rules.
module tb_pc_unit;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] RV   = 32'h80;
    localparam int unsigned HOLD = 2;

    localparam int MODE_HOLD  = 0;
    localparam int MODE_RUN   = 1;
    localparam int MODE_FAULT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        trap_valid;
    logic [31:0] trap_addr;
    logic        is_comp;
    logic [31:0] pc;
    logic [31:0] pc_seq;
    logic        fetch_valid;
    logic        misalign_fault;
    logic [31:0] misalign_addr;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_maddr;
    bit          m_fv;
    bit          m_fault;
    int          m_mode;
    int          m_elapsed;
    bit          m_known = 1'b0;

    pc_unit #(
        .XLEN              (XLEN),
        .RESET_VECTOR      (RV),
        .RESET_HOLD_CYCLES (HOLD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .fetch_ready    (fetch_ready),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .trap_valid     (trap_valid),
        .trap_addr      (trap_addr),
`ifdef PC_COMPRESSED_EN
        .is_compressed  (is_comp),
`endif
        .pc             (pc),
        .pc_seq         (pc_seq),
        .fetch_valid    (fetch_valid),
        .misalign_fault (misalign_fault),
        .misalign_addr  (misalign_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_step();
`ifdef PC_COMPRESSED_EN
        return is_comp ? 32'd2 : 32'd4;
`else
        return 32'd4;
`endif
    endfunction

    function automatic bit m_bad(input logic [31:0] a);
`ifdef PC_COMPRESSED_EN
        return a[0];
`else
        return a[1:0] != 2'b00;
`endif
    endfunction

    task automatic model_edge();
        m_fault = 1'b0;
        if (rst) begin
            m_known   = 1'b1;
            m_pc      = RV;
            m_maddr   = '0;
            m_mode    = MODE_HOLD;
            m_elapsed = 0;
        end else if (m_mode == MODE_HOLD) begin
            if (trap_valid) begin
                m_pc   = trap_addr;
                m_mode = MODE_RUN;
            end else begin
                m_elapsed++;
                if (m_elapsed >= int'(HOLD)) m_mode = MODE_RUN;
            end
        end else if (m_mode == MODE_RUN) begin
            if (trap_valid) m_pc = trap_addr;
            else if (redirect_valid && !m_bad(redirect_addr)) m_pc = redirect_addr;
            else if (redirect_valid) begin
                m_fault = 1'b1;
                m_maddr = redirect_addr;
                m_mode  = MODE_FAULT;
            end else if (!stall && fetch_ready) m_pc = m_pc + m_step();
        end else if (trap_valid) begin
            m_pc   = trap_addr;
            m_mode = MODE_RUN;
        end
        m_fv = (m_mode == MODE_RUN);
    endtask

    // One clock: inputs already driven; check combinational link value, clock, check state.
    task automatic cyc();
        #1;
        if (m_known) check("pc_seq", pc_seq, m_pc + m_step());
        @(posedge clk);
        model_edge();
        #1;
        check("pc", pc, m_pc);
        check("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_fv});
        check("misalign_fault", {31'b0, misalign_fault}, {31'b0, m_fault});
        check("misalign_addr", misalign_addr, m_maddr);
    endtask

    task automatic idle();
        rst = 0; stall = 0; fetch_ready = 1; redirect_valid = 0; trap_valid = 0;
    endtask

    logic [31:0] bad_target;

    initial begin
        idle();
        redirect_addr = '0; trap_addr = '0; is_comp = 0;
        rst = 1;
        cyc(); cyc();
        check("rst_pc", pc, 32'h80);
        check("rst_fv", {31'b0, fetch_valid}, 32'h0);
        check("rst_maddr", misalign_addr, 32'h0);

        // hold window then sequential fetch
        idle();
        cyc(); check("hold1_fv", {31'b0, fetch_valid}, 32'h0);
        cyc(); check("hold2_fv", {31'b0, fetch_valid}, 32'h1); check("first_pc", pc, 32'h80);
        cyc(); check("seq_84", pc, 32'h84);
        cyc(); check("seq_88", pc, 32'h88);

        // stall then redirect while stalled
        trap_valid = 1; trap_addr = 32'h10; cyc(); idle();
        stall = 1;
        for (int i = 0; i < 3; i++) begin cyc(); check("stall_hold", pc, 32'h10); end
        redirect_valid = 1; redirect_addr = 32'h200; cyc();
        check("redir_stalled", pc, 32'h200);

        // trap beats redirect
        redirect_valid = 1; redirect_addr = 32'h40; trap_valid = 1; trap_addr = 32'h1000; stall = 0;
        cyc(); check("trap_prio", pc, 32'h1000);
        idle(); cyc(); check("after_trap", pc, 32'h1004);

        // misaligned redirect -> fault, redirects ignored until trap
`ifdef PC_COMPRESSED_EN
        bad_target = 32'h307;
`else
        bad_target = 32'h202;
`endif
        redirect_valid = 1; redirect_addr = bad_target; cyc();
        check("fault_pulse", {31'b0, misalign_fault}, 32'h1);
        check("fault_addr", misalign_addr, bad_target);
        check("fault_pc", pc, 32'h1004);
        check("fault_fv", {31'b0, fetch_valid}, 32'h0);
        redirect_addr = 32'h400; cyc();
        check("fault_once", {31'b0, misalign_fault}, 32'h0);
        check("fault_ignore", pc, 32'h1004);
        idle(); trap_valid = 1; trap_addr = 32'h1000; cyc();
        check("fault_exit_pc", pc, 32'h1000);
        check("fault_exit_fv", {31'b0, fetch_valid}, 32'h1);
        check("fault_addr_kept", misalign_addr, bad_target);

        // wrap at top of address space
        trap_addr = 32'hFFFF_FFFC; cyc(); idle(); cyc();
        check("wrap_pc", pc, 32'h0);
        check("wrap_nofault", {31'b0, misalign_fault}, 32'h0);

`ifdef PC_COMPRESSED_EN
        trap_valid = 1; trap_addr = 32'h100; cyc(); idle();
        is_comp = 1; cyc(); check("c_step", pc, 32'h102);
        is_comp = 0;
        redirect_valid = 1; redirect_addr = 32'h306; cyc(); check("c_half_ok", pc, 32'h306);
        redirect_addr = 32'h307; cyc(); check("c_odd_fault", {31'b0, misalign_fault}, 32'h1);
`else
        redirect_valid = 1; redirect_addr = 32'h306; cyc(); check("half_fault", {31'b0, misalign_fault}, 32'h1);
`endif

        // reset while in fault
        idle(); rst = 1; cyc();
        check("rst_fault_pc", pc, 32'h80);
        check("rst_fault_maddr", misalign_addr, 32'h0);
        idle();

        for (int n = 0; n < 3000; n++) begin
            rst            = ($urandom_range(99) == 0);
            stall          = ($urandom_range(3) == 0);
            fetch_ready    = ($urandom_range(3) != 0);
            redirect_valid = ($urandom_range(5) == 0);
            redirect_addr  = $urandom;
            if ($urandom_range(3) != 0) redirect_addr[1:0] = 2'b00;
            trap_valid     = ($urandom_range(11) == 0);
            trap_addr      = $urandom;
            if ($urandom_range(7) == 0) trap_addr = 32'hFFFF_FFF0 | ($urandom & 32'hE);
            is_comp        = $urandom_range(1) != 0;
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised fetch-stage program counter for the RV32E core; successor to the single-cycle PC register. Adds:
- configurable width and reset vector
- a valid/ready fetch handshake with stall
- prioritised trap/redirect inputs
- misaligned-target detection with a fault/halt state machine

Sits between branch/trap resolution and instruction memory; drives the fetch address and the sequential PC for link-register writeback.

Parameters:
XLEN, 32, width of all address ports and of the PC register
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be aligned to the increment size
RESET_HOLD_CYCLES, 1, cycles after reset release before fetch_valid first asserts (range 1..15)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
stall  input  1  pipeline stall; holds PC when no redirect/trap is present
fetch_ready  input  1  instruction memory accepts the current fetch address
redirect_valid  input  1  branch/jump resolved taken
redirect_addr  input  XLEN  branch/jump target
trap_valid  input  1  trap or exception entry
trap_addr  input  XLEN  trap vector (from mtvec)
pc  output  XLEN  current fetch address
pc_seq  output  XLEN  pc + increment (combinational), used as the link value
fetch_valid  output  1  pc is a valid fetch request
misalign_fault  output  1  one-cycle pulse: redirect target was misaligned
misalign_addr  output  XLEN  offending target, held until the next fault or reset

Behaviour:
- Reset, sync, active-high, highest priority:
  - pc=RESET_VECTOR, fetch_valid=0, misalign_fault=0, misalign_addr=0
  - state=HOLD, hold counter=0
- States: HOLD, RUN, FAULT.
- HOLD:
  - fetch_valid=0
  - counter increments each cycle; at RESET_HOLD_CYCLES-1 it moves to RUN
  - trap_valid in HOLD loads trap_addr and goes to RUN immediately
  - redirect_valid is ignored in HOLD
- RUN: fetch_valid=1. Per-cycle priority:
  1. trap_valid: pc<=trap_addr (no alignment check).
  2. redirect_valid with aligned target: pc<=redirect_addr.
  3. redirect_valid with misaligned target: pc unchanged; misalign_fault=1 next cycle; misalign_addr<=redirect_addr; go to FAULT.
  4. stall=1 or fetch_ready=0: pc held.
  5. Otherwise pc<=pc_seq.
- Redirect and trap override stall and fetch_ready; the fetch in flight is abandoned.
- FAULT:
  - fetch_valid=0, pc held
  - misalign_fault pulses only on the entry cycle
  - redirect_valid ignored
  - trap_valid loads trap_addr, goes to RUN, and fetch_valid asserts the cycle after
- Alignment: without the optional feature, misaligned means target[1:0]!=0.
- Arithmetic: pc_seq = pc + increment, modulo 2^XLEN. Wrap from all-ones region to 0 is legal and silent.
- Timing: all updates visible the cycle after the qualifying edge. pc and fetch_valid are registered; pc_seq is combinational from pc.
- Reset asserted mid-stall, mid-fault or mid-redirect overrides everything.

Optional Feature:
PC_COMPRESSED_EN
- Defined:
  - adds input is_compressed (1 bit, qualifies the current fetch)
  - increment=2 when is_compressed=1, else 4
  - misaligned means target[0]!=0, so targets with [1:0]=2'b10 are legal
- Undefined:
  - port absent, increment fixed at 4
  - misaligned means target[1:0]!=0

Test Plan:
- Reset with RESET_VECTOR=32'h80, RESET_HOLD_CYCLES=2; release rst -> fetch_valid=0 for 2 cycles, then 1. With fetch_ready=1, pc reads 80, 84, 88 on successive cycles.
- stall=1 for 3 cycles at pc=32'h10, then redirect_valid=1 with addr 32'h200 while still stalled -> pc holds 10, then becomes 200 the next cycle.
- redirect_valid=1 and trap_valid=1 in the same cycle (redirect 32'h40, trap 32'h1000) -> pc=1000.
- redirect_addr=32'h202 in RUN (macro off) -> misalign_fault pulses one cycle, misalign_addr=202, pc held, fetch_valid=0. Redirects are ignored until trap_valid with 32'h1000 -> pc=1000, fetch_valid=1.
- pc=32'hFFFF_FFFC, fetch_ready=1 -> next pc=0, no fault.
- PC_COMPRESSED_EN defined:
  - pc=32'h100, is_compressed=1 -> pc=102
  - redirect to 32'h306 is accepted
  - redirect to 32'h307 raises a fault
